// File: rtl/scan_sel_ctrl.sv
// Position sequencer for the 3-to-8 active-low decoder: steps the select through
// 0..LAST_IDX with a prescaled dwell and an optional disabled gap between positions.
module scan_sel_ctrl #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 0,
    parameter int LAST_IDX  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic       dir,
    output logic [2:0] sel_out,
    output logic [2:0] en_out,
    output logic       busy,
    output logic       sweep_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [2:0]    LAST      = 3'(LAST_IDX);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [BW-1:0] BLANK_MAX = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [BW-1:0] blank_cnt, blank_nxt;
    logic [2:0]    sel_nxt;
    logic          mode_q, dir_q, mode_nxt, dir_nxt, done_nxt;
    logic          show_end, blank_end, at_end;

    assign show_end  = (state == SHOW) && (presc == PRESC_MAX);
    assign blank_end = (state == BLANK) && (blank_cnt == BLANK_MAX);
    assign at_end    = (sel_out == (dir_q ? 3'd0 : LAST));

    // Wrapping step within 0..LAST; indices above LAST are never produced.
    function automatic logic [2:0] adv(input logic [2:0] s, input logic down);
        if (down) return (s == 3'd0) ? LAST : s - 3'd1;
        return (s == LAST) ? 3'd0 : s + 3'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) state_nxt = SHOW;
                SHOW: begin
                    if (show_end) begin
                        if (mode_q && at_end)   state_nxt = IDLE;
                        else if (BLANK_CYC > 0) state_nxt = BLANK;
                        else                    state_nxt = SHOW;
                    end
                end
                BLANK: if (blank_end) state_nxt = SHOW;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the counters and registered outputs.
    always_comb begin
        sel_nxt   = sel_out;
        presc_nxt = presc;
        blank_nxt = blank_cnt;
        mode_nxt  = mode_q;
        dir_nxt   = dir_q;
        done_nxt  = 1'b0;
        if (stop) begin
            presc_nxt = '0;
            blank_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    presc_nxt = '0;
                    blank_nxt = '0;
                    if (start) begin
                        mode_nxt = mode;
                        dir_nxt  = dir;
                        sel_nxt  = dir ? LAST : 3'd0;
                    end
                end
                SHOW: begin
                    if (show_end) begin
                        presc_nxt = '0;
                        done_nxt  = at_end;
                        // Without a gap the next position follows immediately.
                        if (state_nxt == SHOW) sel_nxt = adv(sel_out, dir_q);
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_end) begin
                        blank_nxt = '0;
                        sel_nxt   = adv(sel_out, dir_q);
                    end else begin
                        blank_nxt = blank_cnt + 1'b1;
                    end
                end
                default: begin
                    presc_nxt = '0;
                    blank_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_out    <= 3'd0;
            en_out     <= 3'b000;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            presc      <= '0;
            blank_cnt  <= '0;
            mode_q     <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            sel_out    <= sel_nxt;
            en_out     <= (state_nxt == SHOW) ? 3'b100 : 3'b000;
            busy       <= (state_nxt != IDLE);
            sweep_done <= done_nxt;
            presc      <= presc_nxt;
            blank_cnt  <= blank_nxt;
            mode_q     <= mode_nxt;
            dir_q      <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Scoreboard bench: two configurations share one stimulus stream; a position-level
// schedule model predicts each cycle's outputs and a monitor compares them.
module tb_scan_sel_ctrl;

    logic clk = 1'b0;
    logic rst_n, start, stop, mode, dir;
    logic [2:0] sel0, en0, sel1, en1;
    logic busy0, done0, busy1, done1;

    always #5 clk = ~clk;

    scan_sel_ctrl #(.DIV(4), .BLANK_CYC(2), .LAST_IDX(7)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .dir(dir),
        .sel_out(sel0), .en_out(en0), .busy(busy0), .sweep_done(done0));

    scan_sel_ctrl #(.DIV(1), .BLANK_CYC(0), .LAST_IDX(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .dir(dir),
        .sel_out(sel1), .en_out(en1), .busy(busy1), .sweep_done(done1));

    typedef struct packed {
        logic [2:0] sel;
        logic [2:0] en;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        logic [2:0] sel;
        bit         en;
        bit         flag;   // final enabled cycle of a sweep's end position
    } ent_t;

    int cfg_div[2]   = '{4, 1};
    int cfg_blank[2] = '{2, 0};
    int cfg_last[2]  = '{7, 4};

    bit         active[2], single[2], down[2], flag_prev[2], cur_busy[2];
    int         pos[2];
    logic [2:0] last_sel[2];
    ent_t       sched[2][$];
    obs_t       exp_q[2][$];

    int checks = 0;
    int failures = 0;

    function automatic obs_t act(input int i);
        if (i == 0) return {sel0, en0, busy0, done0};
        return {sel1, en1, busy1, done1};
    endfunction

    task automatic cmp(input int i, input string nm, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got sel=%0d en=%b busy=%b done=%b, want sel=%0d en=%b busy=%b done=%b",
                     nm, i, $time, got.sel, got.en, got.busy, got.done,
                     want.sel, want.en, want.busy, want.done);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            active[i] = 0; single[i] = 0; down[i] = 0; flag_prev[i] = 0; cur_busy[i] = 0;
            pos[i] = 0; last_sel[i] = 3'd0;
            sched[i].delete();
            exp_q[i].delete();
        end
    endtask

    // Expand one position into its enabled cycles and (if the sweep continues) its gap.
    task automatic gen_position(input int i, input int p);
        int e;
        ent_t ent;
        e = down[i] ? 0 : cfg_last[i];
        for (int k = 0; k < cfg_div[i]; k++) begin
            ent = '{sel: 3'(p), en: 1'b1, flag: (k == cfg_div[i] - 1) && (p == e)};
            sched[i].push_back(ent);
        end
        if (single[i] && p == e) begin
            active[i] = 0;
        end else begin
            for (int k = 0; k < cfg_blank[i]; k++) begin
                ent = '{sel: 3'(p), en: 1'b0, flag: 1'b0};
                sched[i].push_back(ent);
            end
            pos[i] = down[i] ? (p + cfg_last[i]) % (cfg_last[i] + 1) : (p + 1) % (cfg_last[i] + 1);
        end
    endtask

    // Predict outputs after the coming clock edge given the inputs sampled at it.
    task automatic step(input int i, input bit s, input bit p, input bit m, input bit d);
        obs_t o;
        ent_t e;
        bit dn;
        dn = p ? 1'b0 : flag_prev[i];
        flag_prev[i] = 0;
        if (p) begin
            sched[i].delete();
            active[i] = 0;
            o = '{sel: last_sel[i], en: 3'b000, busy: 1'b0, done: 1'b0};
        end else begin
            if (s && !cur_busy[i]) begin
                active[i] = 1; single[i] = m; down[i] = d;
                pos[i] = d ? cfg_last[i] : 0;
            end
            if (sched[i].size() == 0 && active[i]) gen_position(i, pos[i]);
            if (sched[i].size() > 0) begin
                e = sched[i].pop_front();
                o = '{sel: e.sel, en: e.en ? 3'b100 : 3'b000, busy: 1'b1, done: dn};
                flag_prev[i] = e.flag;
                last_sel[i] = e.sel;
            end else begin
                o = '{sel: last_sel[i], en: 3'b000, busy: 1'b0, done: dn};
            end
        end
        cur_busy[i] = o.busy;
        exp_q[i].push_back(o);
    endtask

    task automatic cyc(input bit s, input bit p, input bit m, input bit d);
        @(negedge clk);
        start = s; stop = p; mode = m; dir = d;
        for (int i = 0; i < 2; i++) step(i, s, p, m, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) cmp(i, "async_rst", act(i), '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 2; i++) step(i, 1'b0, 1'b0, mode, dir);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int i = 0; i < 2; i++)
                if (exp_q[i].size() > 0) cmp(i, "cycle", act(i), exp_q[i].pop_front());
        end
    end

    initial begin
        start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        for (int i = 0; i < 2; i++) cmp(i, "reset_state", act(i), '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) step(i, 1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous up with mode/dir churn and a redundant start while busy.
        cyc(1, 0, 0, 0);
        repeat (70) cyc(0, 0, 1'($urandom), 1'($urandom));
        cyc(1, 0, 1, 1);
        repeat (70) cyc(0, 0, 1'($urandom), 1'($urandom));
        cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        // Single sweep up, then idle.
        cyc(1, 0, 1, 0);
        repeat (60) cyc(0, 0, 0, 0);
        // Continuous down, then abort.
        cyc(1, 0, 0, 1);
        repeat (100) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        // start and stop together in idle.
        cyc(1, 1, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        // Single sweep down.
        cyc(1, 0, 1, 1);
        repeat (60) cyc(0, 0, 0, 0);
        // Reset during the gap after position 1.
        cyc(1, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0);
        do_reset();
        repeat (5) cyc(0, 0, 0, 0);

        repeat (4000) begin
            if ($urandom % 800 == 0) do_reset();
            else cyc(1'($urandom % 16 == 0), 1'($urandom % 50 == 0), 1'($urandom), 1'($urandom));
        end
        cyc(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                failures++;
                $display("FAIL drain dut%0d: got %0d pending, want 0", i, exp_q[i].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
